// File: rtl/alarm_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alarm_sequencer_pkg
//   Shared definitions for the home alarm sequencer:
//   - state encodings (also exported on the debug 'state' port)
//   - default delay lengths and counter width
// ---------------------------------------------------------------------------
package alarm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } state_t;

    localparam int DEF_EXIT_CYCLES  = 16;
    localparam int DEF_ENTRY_CYCLES = 16;
    localparam int DEF_SIREN_CYCLES = 64;
    localparam int DEF_CNT_W        = 8;

endpackage : alarm_sequencer_pkg

// File: rtl/alarm_delay_timer.sv
// ---------------------------------------------------------------------------
// alarm_delay_timer
//   Loadable down-counter used for exit, entry and siren timing.
//   load has priority over dec; the count never wraps below zero.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   load      in   load load_val this cycle
//   load_val  in   value to load [CNT_W-1:0]
//   dec       in   decrement request (ignored when count is zero)
//   count     out  current count [CNT_W-1:0]
//   zero      out  1 when count == 0
// ---------------------------------------------------------------------------
module alarm_delay_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule : alarm_delay_timer

// File: rtl/alarm_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_sequencer
//   Sequential home alarm controller: arm/disarm tracking, timed exit and
//   entry delays for door/garage, window intrusion, panic, and a
//   time-limited siren. All outputs are registered.
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   panic          in   panic button (level)
//   arm_req        in   arm request pulse
//   disarm_req     in   disarm request pulse (valid code entered)
//   window         in   window sensor, 1 = open
//   door           in   door sensor, 1 = open
//   garage         in   garage sensor, 1 = open
//   alarm          out  siren enable
//   armed          out  1 in ARMED or ENTRY_DELAY
//   exit_pending   out  1 in EXIT_DELAY
//   entry_pending  out  1 in ENTRY_DELAY
//   arm_fault      out  one-cycle pulse when an arm request is refused
//   state          out  current state encoding [2:0]
// ---------------------------------------------------------------------------
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int EXIT_CYCLES  = DEF_EXIT_CYCLES,
    parameter int ENTRY_CYCLES = DEF_ENTRY_CYCLES,
    parameter int SIREN_CYCLES = DEF_SIREN_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       panic,
    input  logic       arm_req,
    input  logic       disarm_req,
    input  logic       window,
    input  logic       door,
    input  logic       garage,
    output logic       alarm,
    output logic       armed,
    output logic       exit_pending,
    output logic       entry_pending,
    output logic       arm_fault,
    output logic [2:0] state
);

    // A delay of N cycles is counted N-1 .. 0 while in the timed state.
    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

    state_t           state_q;
    state_t           state_nx;
    logic             fault_nx;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_zero;

    alarm_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Next-state and timer control. Priority within a cycle:
    // panic > disarm_req > window > door|garage > timer expiry > arm_req.
    always_comb begin
        state_nx     = state_q;
        fault_nx     = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        if (panic) begin
            // Reloading every cycle keeps the siren running while panic is held.
            state_nx     = ST_ALARM;
            tmr_load     = 1'b1;
            tmr_load_val = SIREN_LOAD;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    // A simultaneous disarm cancels the arm attempt silently.
                    if (arm_req && !disarm_req) begin
                        if (window || door || garage) begin
                            fault_nx = 1'b1;
                        end else begin
                            state_nx     = ST_EXIT_DELAY;
                            tmr_load     = 1'b1;
                            tmr_load_val = EXIT_LOAD;
                        end
                    end
                end

                ST_EXIT_DELAY: begin
                    // door/garage are expected here: the occupant is leaving.
                    if (disarm_req) begin
                        state_nx = ST_DISARMED;
                    end else if (window) begin
                        state_nx     = ST_ALARM;
                        tmr_load     = 1'b1;
                        tmr_load_val = SIREN_LOAD;
                    end else if (tmr_zero) begin
                        state_nx = ST_ARMED;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end

                ST_ARMED: begin
                    if (disarm_req) begin
                        state_nx = ST_DISARMED;
                    end else if (window) begin
                        state_nx     = ST_ALARM;
                        tmr_load     = 1'b1;
                        tmr_load_val = SIREN_LOAD;
                    end else if (door || garage) begin
                        state_nx     = ST_ENTRY_DELAY;
                        tmr_load     = 1'b1;
                        tmr_load_val = ENTRY_LOAD;
                    end
                end

                ST_ENTRY_DELAY: begin
                    // Further door/garage activity must not restart the delay.
                    if (disarm_req) begin
                        state_nx = ST_DISARMED;
                    end else if (window || tmr_zero) begin
                        state_nx     = ST_ALARM;
                        tmr_load     = 1'b1;
                        tmr_load_val = SIREN_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end

                ST_ALARM: begin
                    // Siren timeout re-arms the system rather than disarming it.
                    if (disarm_req) begin
                        state_nx = ST_DISARMED;
                    end else if (tmr_zero) begin
                        state_nx = ST_ARMED;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end

                default: begin
                    state_nx = ST_DISARMED;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state, so every
    // output is a flop that lines up with the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_DISARMED;
            alarm         <= 1'b0;
            armed         <= 1'b0;
            exit_pending  <= 1'b0;
            entry_pending <= 1'b0;
            arm_fault     <= 1'b0;
        end else begin
            state_q       <= state_nx;
            alarm         <= (state_nx == ST_ALARM);
            armed         <= (state_nx == ST_ARMED) || (state_nx == ST_ENTRY_DELAY);
            exit_pending  <= (state_nx == ST_EXIT_DELAY);
            entry_pending <= (state_nx == ST_ENTRY_DELAY);
            arm_fault     <= fault_nx;
        end
    end

    assign state = state_q;

endmodule : alarm_sequencer

// File: tb/tb_alarm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alarm_sequencer
//   Directed bench for alarm_sequencer with EXIT=4, ENTRY=3, SIREN=5.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge that follows each rising edge.
// ---------------------------------------------------------------------------
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       panic, arm_req, disarm_req, window, door, garage;
    logic       alarm, armed, exit_pending, entry_pending, arm_fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int alarm_cycles;

    // Output vector: {state[2:0], alarm, armed, exit_pending, entry_pending, arm_fault}
    localparam logic [7:0] V_DIS   = {3'd0, 5'b00000};
    localparam logic [7:0] V_FAULT = {3'd0, 5'b00001};
    localparam logic [7:0] V_EXIT  = {3'd1, 5'b00100};
    localparam logic [7:0] V_ARMED = {3'd2, 5'b01000};
    localparam logic [7:0] V_ENTRY = {3'd3, 5'b01010};
    localparam logic [7:0] V_ALARM = {3'd4, 5'b10000};

    alarm_sequencer #(
        .EXIT_CYCLES  (4),
        .ENTRY_CYCLES (3),
        .SIREN_CYCLES (5),
        .CNT_W        (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .panic         (panic),
        .arm_req       (arm_req),
        .disarm_req    (disarm_req),
        .window        (window),
        .door          (door),
        .garage        (garage),
        .alarm         (alarm),
        .armed         (armed),
        .exit_pending  (exit_pending),
        .entry_pending (entry_pending),
        .arm_fault     (arm_fault),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {state, alarm, armed, exit_pending, entry_pending, arm_fault};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        panic = 1'b0; arm_req = 1'b0; disarm_req = 1'b0;
        window = 1'b0; door = 1'b0; garage = 1'b0;

        // Reset state, then asynchronous reset in the middle of ALARM
        step(); step();
        chk("reset_hold", V_DIS);
        rst_n = 1'b1;
        step();
        chk("after_reset", V_DIS);
        panic = 1'b1;
        step();
        panic = 1'b0;
        chk("panic_one", V_ALARM);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", V_DIS);
        step();
        rst_n = 1'b1;
        step();
        chk("post_async_reset", V_DIS);

        // Arm with all sensors closed, exit delay, then timed entry
        arm_req = 1'b1;
        step();
        arm_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("exit_%0d", i), V_EXIT);
            step();
        end
        chk("armed_after_exit", V_ARMED);
        door = 1'b1;
        step();
        door = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("entry_%0d", i), V_ENTRY);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("siren_%0d", i), V_ALARM);
            step();
        end
        chk("rearm_after_siren", V_ARMED);

        // Refused arm, then door open during exit delay
        disarm_req = 1'b1;
        step();
        disarm_req = 1'b0;
        chk("disarm_from_armed", V_DIS);
        garage = 1'b1;
        arm_req = 1'b1;
        step();
        arm_req = 1'b0;
        chk("arm_fault_pulse", V_FAULT);
        step();
        chk("arm_fault_clears", V_DIS);
        // Arm and disarm together: disarm wins, no fault even with garage open
        arm_req = 1'b1;
        disarm_req = 1'b1;
        step();
        arm_req = 1'b0;
        disarm_req = 1'b0;
        garage = 1'b0;
        chk("arm_disarm_same_cycle", V_DIS);
        arm_req = 1'b1;
        step();
        arm_req = 1'b0;
        door = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("exit_door_%0d", i), V_EXIT);
            step();
        end
        chk("armed_despite_door", V_ARMED);
        door = 1'b0;

        // Window while armed goes straight to ALARM; disarm in its 2nd cycle
        window = 1'b1;
        step();
        window = 1'b0;
        chk("window_alarm_c1", V_ALARM);
        step();
        chk("window_alarm_c2", V_ALARM);
        disarm_req = 1'b1;
        step();
        disarm_req = 1'b0;
        chk("disarm_from_alarm", V_DIS);

        // Held panic: alarm from the first panic sample until 5 cycles after
        // the last one (7 + 5 = 12 cycles), then the system re-arms.
        alarm_cycles = 0;
        panic = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (alarm) alarm_cycles++;
        end
        panic = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (alarm) alarm_cycles++;
        end
        chk_int("panic_alarm_cycles", alarm_cycles, 12);
        chk("armed_after_panic", V_ARMED);
        panic = 1'b1;
        disarm_req = 1'b1;
        step();
        panic = 1'b0;
        disarm_req = 1'b0;
        chk("panic_beats_disarm", V_ALARM);
        disarm_req = 1'b1;
        step();
        disarm_req = 1'b0;
        chk("disarm_after_panic", V_DIS);

        // Disarm on the final entry-delay cycle: siren never starts
        arm_req = 1'b1;
        step();
        arm_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("armed_again", V_ARMED);
        garage = 1'b1;
        step();
        chk("entry_by_garage_0", V_ENTRY);
        step();
        garage = 1'b0;
        chk("entry_by_garage_1", V_ENTRY);
        step();
        chk("entry_by_garage_2", V_ENTRY);
        disarm_req = 1'b1;
        step();
        disarm_req = 1'b0;
        chk("disarm_last_entry", V_DIS);
        step();
        chk("still_disarmed", V_DIS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alarm_sequencer
